serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Byte-serial transmitter driving the CPU's uart_tx line.
- Accepts output bytes from the CPU OUT path over a valid/ready handshake and serialises them.
- Frame: line idles high, one low start bit, WIDTH data bits LSB first, STOP_BITS high stop bits.
- One-entry holding register, so the CPU can queue the next byte while the current frame is on the wire.

Parameters:
WIDTH, 8, data bits per frame
CLKS_PER_BIT, 2, clk cycles per serial bit (2 matches a line sampler at clk/2); legal values >= 1
STOP_BITS, 1, number of high stop bits per frame; legal values >= 1

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  reset, asynchronous, active-high
data_in  input  WIDTH  byte to send; sampled when valid && ready
valid  input  1  producer has a byte on data_in
ready  output  1  holding register empty; byte accepted on the clk edge where valid && ready
tx  output  1  serial line, registered
busy  output  1  high while a frame is on the line or the holding register is full

Behaviour:
- Reset (async assert, sync-free release):
  - tx=1, ready=1, busy=0.
  - State IDLE; holding register empty; baud counter and bit counter cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high asynchronously and the queued byte is dropped.
- Holding register:
  - Accept sets it full.
  - Loading into the shift register empties it, in the same edge that enters START.
  - ready = !full (registered).
  - An accept and a load in the same cycle leave it full with the new byte.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Wraps to 0 on the bit-end tick and is cleared on every state entry.
  - Each bit holds tx for exactly CLKS_PER_BIT cycles.
- FSM:
  - IDLE: if the holding register is full, load the shift register and go to START.
  - START: tx=0. On tick, go to DATA with bit_cnt=0.
  - DATA: tx=shift[0]. On tick, shift right. When bit_cnt==WIDTH-1, go to STOP; otherwise bit_cnt++.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, if the holding register is full, load and go directly to START (back-to-back frames, no extra idle bit); otherwise go to IDLE.
- Latency:
  - Byte accepted at edge N (idle) → holding register full after edge N.
  - START entered at edge N+1; tx=0 from edge N+2 (tx is registered from the state).
  - Frame length = (1+WIDTH+STOP_BITS)*CLKS_PER_BIT cycles.
- busy = (state != IDLE) || full.
- valid with ready low: no accept, and the byte is not sampled; the producer holds data_in.
- data_in changes after accept do not affect the frame in flight.
- Width rules:
  - bit_cnt width is $clog2(WIDTH), minimum 1.
  - Baud counter width is $clog2(CLKS_PER_BIT), minimum 1.
  - Stop counter covers STOP_BITS*CLKS_PER_BIT.
  - No truncation warnings permitted.

Decomposition:
- Shared package (serial_pkg): state encoding localparams (IDLE, START, DATA, STOP) and frame-length constant helpers. Reused by a future serial_rx.
- Sub-module serial_baud_gen: the counter with clear input and tick output. Natural to split and shared with the receiver.
- Everything else stays in serial_tx.

Test Plan:
- Reset, then send 0x06 with CLKS_PER_BIT=2 → tx idles 1, then start 0 for 2 clks, then bits 0,1,1,0,0,0,0,0 each 2 clks, then 1 for 2 clks. Line sampler reconstructs 0x06.
- Back-to-back: valid held for 0xA5 then 0x3C → second byte accepted while the first is in DATA. Exactly one stop period separates the frames (no extra idle). Sampler receives 0xA5 then 0x3C; ready low between accept and START of frame 2.
- Backpressure: valid held during a frame with the holding register full → ready=0 and the byte is not taken. Changing data_in while ready=0 sends only the value present at the accepting edge.
- Reset asserted mid-DATA of 0xFF → tx=1 within the same cycle (async). After release ready=1, busy=0, no residual frame.
- Parameter sweep CLKS_PER_BIT=1 and 5, STOP_BITS=2: send 0x81 → start bit width equals CLKS_PER_BIT, stop width 2*CLKS_PER_BIT, and total frame cycles match the formula.
- Multiplier-product sequence: drive all products a*b for a,b in 0..15 (e.g. 15*15=0xE1) → sampler matches every byte in order with no drops.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter and a future receiver.
// Holds the line-state encoding and the helpers that size counters and frames.
// Has no logic of its own, so it adds no latency and applies no backpressure.
package serial_pkg;

  // Line states for one UART-style frame: idle-high, start, data, stop
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } serial_state_e;

  // Width of a counter that must hold the values 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Clock cycles spent in the stop period of one frame
  function automatic int stop_cycles(input int clks_per_bit, input int stop_bits);
    return clks_per_bit * stop_bits;
  endfunction

  // Clock cycles for a whole frame: start bit, data bits, stop bits
  function automatic int frame_cycles(input int width, input int clks_per_bit,
                                      input int stop_bits);
    return (1 + width + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// serial_baud_gen: bit-period counter; o_tick marks the last cycle of each serial bit.
// Tick is combinational from the count, so it is high in the final cycle of a bit.
// No backpressure; i_clr restarts the bit period from zero on the next edge.
module serial_baud_gen
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last;

  // Count 0..CLKS_PER_BIT-1, wrapping on the tick and restarting on clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: byte-serial transmitter, 1 start bit, WIDTH data bits LSB first, STOP_BITS stop.
// Accept at edge N -> START at N+1 -> tx low from N+2; frames run back to back when queued.
// One-entry holding register: ready drops after an accept and rises when the byte is loaded.
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             tx,
  output logic             busy
);

  localparam int BCW      = cnt_width(WIDTH);
  localparam int STOP_LEN = stop_cycles(CLKS_PER_BIT, STOP_BITS);
  localparam int SCW      = cnt_width(STOP_LEN);

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);
  localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_LEN - 1);

  serial_state_e    r_state;
  logic [WIDTH-1:0] r_hold;
  logic             r_full;
  logic             r_ready;
  logic [WIDTH-1:0] r_shift;
  logic [BCW-1:0]   r_bit_cnt;
  logic [SCW-1:0]   r_stop_cnt;
  logic             r_tx;

  logic w_tick;
  logic w_accept;
  logic w_last_bit;
  logic w_stop_end;
  logic w_load;
  logic w_enter;
  logic w_baud_clr;

  // Handshake: the byte is taken only on an edge where the holding register is empty
  assign w_accept   = valid && r_ready;
  assign w_last_bit = (r_bit_cnt == BIT_LAST);
  assign w_stop_end = (r_state == ST_STOP) && (r_stop_cnt == STOP_LAST);

  // Moving the held byte into the shift register happens from IDLE, or straight
  // out of the stop period so queued frames follow with no idle gap
  assign w_load = r_full && ((r_state == ST_IDLE) || w_stop_end);

  // Every state entry restarts the bit period; IDLE keeps the counter parked at 0
  assign w_enter = w_load
                || ((r_state == ST_START) && w_tick)
                || ((r_state == ST_DATA) && w_tick && w_last_bit)
                || w_stop_end;
  assign w_baud_clr = w_enter || (r_state == ST_IDLE);

  serial_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_baud_clr),
    .o_tick (w_tick)
  );

  // Holding register: an accept wins over a load so the new byte stays queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_ready <= 1'b1;
    end else if (w_accept) begin
      r_hold  <= data_in;
      r_full  <= 1'b1;
      r_ready <= 1'b0;
    end else if (w_load) begin
      r_full  <= 1'b0;
      r_ready <= 1'b1;
    end
  end

  // Frame sequencer; tx is registered from the state held during the current cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (r_full) begin
            r_shift <= r_hold;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_tx <= 1'b0;
          if (w_tick) begin
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          r_tx <= r_shift[0];
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            if (w_last_bit) begin
              r_stop_cnt <= '0;
              r_state    <= ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_stop_end) begin
            if (r_full) begin
              r_shift <= r_hold;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign tx    = r_tx;
  assign busy  = (r_state != ST_IDLE) || r_full;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: three transmitters (CLKS_PER_BIT/STOP_BITS = 2/1, 5/2, 1/2) driven by directed steps.
// Accepted bytes go into per-instance queues; a line sampler pops them at each start bit
// and checks every sampled cycle of the frame plus the reassembled byte.
module tb_serial_tx;

  localparam int W = 8;
  localparam int CPB0 = 2;
  localparam int SB0  = 1;
  localparam int CPB1 = 5;
  localparam int SB1  = 2;
  localparam int CPB2 = 1;
  localparam int SB2  = 2;
  localparam int L0   = (1 + W + SB0) * CPB0;

  logic                clk;
  logic                rst;
  logic [2:0][W-1:0]   din;
  logic [2:0]          valid;
  logic [2:0]          ready;
  logic [2:0]          tx;
  logic [2:0]          busy;

  int checks;
  int failures;
  int cyc;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

  bit   [2:0]        in_frame;
  logic [2:0][W-1:0] exp_b;
  logic [2:0][W-1:0] rx_b;
  int                pos      [3];
  int                bad      [3];
  int                bad_pos  [3];
  int                start_cyc[3];
  int                gap      [3];
  int                frames   [3];

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB0), .STOP_BITS(SB0)) u_dut0 (
    .clk(clk), .rst(rst), .data_in(din[0]), .valid(valid[0]),
    .ready(ready[0]), .tx(tx[0]), .busy(busy[0]));

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB1), .STOP_BITS(SB1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .valid(valid[1]),
    .ready(ready[1]), .tx(tx[1]), .busy(busy[1]));

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB2), .STOP_BITS(SB2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(din[2]), .valid(valid[2]),
    .ready(ready[2]), .tx(tx[2]), .busy(busy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int cpb_of(input int k);
    case (k)
      0:       return CPB0;
      1:       return CPB1;
      default: return CPB2;
    endcase
  endfunction

  function automatic int len_of(input int k);
    int sb;
    case (k)
      0:       sb = SB0;
      1:       sb = SB1;
      default: sb = SB2;
    endcase
    return (1 + W + sb) * cpb_of(k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic q_push(input int k, input logic [W-1:0] b);
    case (k)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  task automatic q_pop(input int k, output bit ok, output logic [W-1:0] b);
    ok = 1'b0;
    b  = '0;
    case (k)
      0:       if (q0.size() > 0) begin b = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin b = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin b = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // Line sampler: one sample per cycle on the falling edge
  initial begin : sampler
    bit           ok;
    logic [W-1:0] e;
    logic         eb;
    int           c;
    int           p;
    for (int k = 0; k < 3; k++) begin
      pos[k] = 0; bad[k] = 0; bad_pos[k] = 0;
      start_cyc[k] = 0; gap[k] = 0; frames[k] = 0;
    end
    in_frame = '0;
    exp_b    = '0;
    rx_b     = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          in_frame[k] = 1'b0;
        end else if (in_frame[k] || tx[k] === 1'b0) begin
          if (!in_frame[k]) begin
            q_pop(k, ok, e);
            chk($sformatf("i%0d_frame_expected", k), {31'd0, ok}, 32'd1);
            exp_b[k]     = e;
            gap[k]       = cyc - start_cyc[k];
            start_cyc[k] = cyc;
            pos[k]       = 0;
            bad[k]       = 0;
            rx_b[k]      = '0;
            in_frame[k]  = 1'b1;
          end else begin
            pos[k]++;
          end
          c = cpb_of(k);
          p = pos[k] / c;
          if (p == 0)       eb = 1'b0;
          else if (p <= W)  eb = exp_b[k][p-1];
          else              eb = 1'b1;
          if (tx[k] !== eb) begin
            if (bad[k] == 0) bad_pos[k] = pos[k];
            bad[k]++;
          end
          if (p >= 1 && p <= W && (pos[k] % c) == (c / 2)) rx_b[k][p-1] = tx[k];
          if (pos[k] == len_of(k) - 1) begin
            chk($sformatf("i%0d_shape_bad_cycles_first_at_%0d", k, bad_pos[k]), bad[k], 0);
            chk($sformatf("i%0d_data", k), {24'd0, rx_b[k]}, {24'd0, exp_b[k]});
            frames[k]++;
            in_frame[k] = 1'b0;
          end
        end
      end
    end
  end

  // Offer a byte from a falling edge and hold it until the accepting rising edge
  task automatic send(input int k, input logic [W-1:0] b);
    int n;
    n = 0;
    din[k]   = b;
    valid[k] = 1'b1;
    while (ready[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("i%0d_send_wait_ok", k), {31'd0, (n < 200)}, 32'd1);
    @(posedge clk);
    q_push(k, b);
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int target, input int bound);
    int n;
    n = 0;
    while (frames[k] < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("i%0d_frames_reached", k), frames[k], target);
  endtask

  initial begin : stim
    int base;
    int fr_before;
    rst   = 1'b1;
    valid = '0;
    din   = '0;
    repeat (3) @(negedge clk);

    // Reset state on every instance
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("i%0d_rst_tx", k),    {31'd0, tx[k]},    32'd1);
      chk($sformatf("i%0d_rst_ready", k), {31'd0, ready[k]}, 32'd1);
      chk($sformatf("i%0d_rst_busy", k),  {31'd0, busy[k]},  32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single frame 0x06: handshake, start-bit latency, busy duration
    send(0, 8'h06);
    chk("acc_ready_low", {31'd0, ready[0]}, 32'd0);
    chk("acc_busy_high", {31'd0, busy[0]},  32'd1);
    chk("acc_tx_idle",   {31'd0, tx[0]},    32'd1);
    @(negedge clk);
    chk("start_entered_tx_still_high", {31'd0, tx[0]}, 32'd1);
    @(negedge clk);
    chk("start_bit_low", {31'd0, tx[0]}, 32'd0);
    repeat (L0 - 2) @(negedge clk);
    chk("busy_in_last_stop_cycle", {31'd0, busy[0]}, 32'd1);
    @(negedge clk);
    chk("busy_clear_after_frame", {31'd0, busy[0]}, 32'd0);
    chk("ready_after_frame",      {31'd0, ready[0]}, 32'd1);
    wait_frames(0, 1, 50);

    // Back-to-back 0xA5 then 0x3C
    base = frames[0];
    send(0, 8'hA5);
    send(0, 8'h3C);
    chk("b2b_ready_low_queued", {31'd0, ready[0]}, 32'd0);
    repeat (L0 - 4) @(negedge clk);
    chk("b2b_ready_low_until_load", {31'd0, ready[0]}, 32'd0);
    wait_frames(0, base + 2, 4 * L0);
    chk("b2b_frame_gap", gap[0], L0);

    // Backpressure: 0x99 offered while full must never be sent; 0x44 replaces it
    base = frames[0];
    send(0, 8'h11);
    send(0, 8'h22);
    din[0]   = 8'h99;
    valid[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_ready_low", {31'd0, ready[0]}, 32'd0);
    chk("bp_busy_high", {31'd0, busy[0]},  32'd1);
    send(0, 8'h44);
    wait_frames(0, base + 3, 6 * L0);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of the data bits of 0xFF with 0x55 queued
    send(0, 8'hFF);
    send(0, 8'h55);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy[0]}, 32'd1);
    fr_before = frames[0];
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx",    {31'd0, tx[0]},    32'd1);
    chk("async_rst_ready", {31'd0, ready[0]}, 32'd1);
    chk("async_rst_busy",  {31'd0, busy[0]},  32'd0);
    q0.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (L0 + 5) @(negedge clk);
    chk("post_rst_ready",     {31'd0, ready[0]}, 32'd1);
    chk("post_rst_busy",      {31'd0, busy[0]},  32'd0);
    chk("post_rst_tx",        {31'd0, tx[0]},    32'd1);
    chk("post_rst_no_frames", frames[0], fr_before);

    // Timing sweep: 0x81 twice back to back on the 5/2 and 1/2 instances
    for (int k = 1; k < 3; k++) begin
      base = frames[k];
      send(k, 8'h81);
      send(k, 8'h81);
      wait_frames(k, base + 2, 4 * len_of(k));
      chk($sformatf("i%0d_frame_len", k), gap[k], len_of(k));
    end

    // Every product a*b for a,b in 0..15, in order, no drops
    base = frames[0];
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(0, 8'(a * b));
      end
    end
    wait_frames(0, base + 256, 4 * L0);
    repeat (3) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("i%0d_queue_drained", k), q_size(k), 0);
      chk($sformatf("i%0d_idle_at_end", k), {31'd0, busy[k]}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
